// File: rtl/round_robin_or_bus_arbiter_pkg.sv
// rtl/round_robin_or_bus_arbiter_pkg.sv - shared constants and types for the round-robin OR-bus arbiter
// Purpose: requester count, data width, stall timeout, counter width and FSM state encoding.
package round_robin_or_bus_arbiter_pkg;

  localparam int N_REQ   = 8;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/round_robin_or_bus_arbiter_rr_pick8.sv
// rtl/round_robin_or_bus_arbiter_rr_pick8.sv - combinational 8-way round-robin picker
// Purpose: find the first set request bit starting at ptr_i and wrapping modulo 8.
// Ports:
//   req_i    : request vector
//   ptr_i    : search start position
//   onehot_o : one-hot selection, zero when no request
//   idx_o    : index of the selection, zero when no request
//   any_o    : at least one request present
module rr_pick8 (
  input  logic [7:0] req_i,
  input  logic [2:0] ptr_i,
  output logic [7:0] onehot_o,
  output logic [2:0] idx_o,
  output logic       any_o
);

  logic [2:0] cand;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = '0;
    for (int k = 0; k < 8; k++) begin
      // 3-bit addition wraps naturally, giving the modulo-8 search order
      cand = ptr_i + 3'(k);
      if (!any_o && req_i[cand]) begin
        any_o          = 1'b1;
        idx_o          = cand;
        onehot_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/round_robin_or_bus_arbiter.sv
// rtl/round_robin_or_bus_arbiter.sv - round-robin arbiter with locked bursts, stall eviction and OR-bus data mux
// Purpose: grants one of eight requesters, holds the grant until a last-beat handshake or an idle timeout,
//          and drives the owner's data onto an AND-OR bus.
// Ports:
//   CLK        : clock, rising edge
//   ASYNCRESET : asynchronous active-high reset
//   req        : per-requester request/valid
//   last       : per-requester final-beat marker (only meaningful for the owner on a handshake)
//   I0..I7     : per-requester data
//   ready      : sink accepts the current beat
//   gnt        : registered one-hot grant, zero when idle
//   owner      : index of the granted requester, zero when idle
//   valid      : owner is requesting while granted
//   O          : OR-bus of granted requester data
//   abort      : one-cycle pulse on timeout eviction
module round_robin_or_bus_arbiter #(
  parameter int N_REQ   = round_robin_or_bus_arbiter_pkg::N_REQ,
  parameter int WIDTH   = round_robin_or_bus_arbiter_pkg::WIDTH,
  parameter int TIMEOUT = round_robin_or_bus_arbiter_pkg::TIMEOUT
) (
  input  logic                     CLK,
  input  logic                     ASYNCRESET,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         last,
  input  logic [WIDTH-1:0]         I0,
  input  logic [WIDTH-1:0]         I1,
  input  logic [WIDTH-1:0]         I2,
  input  logic [WIDTH-1:0]         I3,
  input  logic [WIDTH-1:0]         I4,
  input  logic [WIDTH-1:0]         I5,
  input  logic [WIDTH-1:0]         I6,
  input  logic [WIDTH-1:0]         I7,
  input  logic                     ready,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     valid,
  output logic [WIDTH-1:0]         O,
  output logic                     abort
);

  import round_robin_or_bus_arbiter_pkg::*;

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;

  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             hs;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] data [N_REQ];
  logic [WIDTH-1:0] o_acc;

  rr_pick8 u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign data[0] = I0;
  assign data[1] = I1;
  assign data[2] = I2;
  assign data[3] = I3;
  assign data[4] = I4;
  assign data[5] = I5;
  assign data[6] = I6;
  assign data[7] = I7;

  // AND-mask each requester with its grant bit, then OR-reduce; an empty grant yields zero
  always_comb begin
    o_acc = '0;
    for (int i = 0; i < N_REQ; i++) begin
      o_acc = o_acc | (data[i] & {WIDTH{gnt_q[i]}});
    end
  end

  assign valid = req[owner_q] & (|gnt_q);
  assign hs    = valid & ready;

  // Idle counter saturates so a long stall can never wrap back below the threshold
  assign cnt_inc = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        gnt_d   = '0;
        owner_d = '0;
        cnt_d   = '0;
        if (pick_any) begin
          gnt_d   = pick_onehot;
          owner_d = pick_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (hs && last[owner_q]) begin
          ptr_d   = owner_q + IDX_W'(1);
          gnt_d   = '0;
          owner_d = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (req[owner_q]) begin
          // Owner still present (stalled by ready or mid-burst): not idle
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          // Evict on the edge where the count reaches the threshold
          if (cnt_inc == TIMEOUT_C) begin
            abort_d = 1'b1;
            ptr_d   = owner_q + IDX_W'(1);
            gnt_d   = '0;
            owner_d = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        owner_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign O     = o_acc;
  assign abort = abort_q;

endmodule

// File: tb/tb_round_robin_or_bus_arbiter.sv
// tb/tb_round_robin_or_bus_arbiter.sv - scoreboard testbench for round_robin_or_bus_arbiter
module tb_round_robin_or_bus_arbiter;

  logic       CLK = 1'b0;
  logic       ASYNCRESET;
  logic [7:0] req, last;
  logic       ready;
  logic [7:0] dat [8];
  logic [7:0] gnt;
  logic [2:0] owner;
  logic       valid;
  logic [7:0] O;
  logic       abort;

  typedef struct {
    logic [7:0] gnt;
    logic [7:0] o;
    logic       valid;
    logic       abort;
    logic [2:0] owner;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  round_robin_or_bus_arbiter dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .req        (req),
    .last       (last),
    .I0         (dat[0]),
    .I1         (dat[1]),
    .I2         (dat[2]),
    .I3         (dat[3]),
    .I4         (dat[4]),
    .I5         (dat[5]),
    .I6         (dat[6]),
    .I7         (dat[7]),
    .ready      (ready),
    .gnt        (gnt),
    .owner      (owner),
    .valid      (valid),
    .O          (O),
    .abort      (abort)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [2:0] idx_of(input logic [7:0] g);
    idx_of = 3'd0;
    for (int i = 0; i < 8; i++) if (g[i]) idx_of = 3'(i);
  endfunction

  // Drive one cycle of inputs and queue the outputs expected during that cycle
  task automatic cyc(input logic [7:0] r, input logic [7:0] l, input logic rd,
                     input logic [7:0] eg, input logic ea);
    exp_t e;
    req   = r;
    last  = l;
    ready = rd;
    e.gnt   = eg;
    e.abort = ea;
    e.owner = idx_of(eg);
    e.o     = (eg != 8'h00) ? dat[e.owner] : 8'h00;
    e.valid = (eg != 8'h00) && r[e.owner];
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  // Monitor: pops one expectation per cycle and compares away from the active edge
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("gnt",   32'(gnt),   32'(e.gnt));
      check("O",     32'(O),     32'(e.o));
      check("valid", 32'(valid), 32'(e.valid));
      check("abort", 32'(abort), 32'(e.abort));
      check("owner", 32'(owner), 32'(e.owner));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ASYNCRESET = 1'b1;
    req   = 8'h00;
    last  = 8'h00;
    ready = 1'b0;
    dat   = '{8'hA5, 8'h3C, 8'h5A, 8'h96, 8'hC3, 8'h69, 8'h0F, 8'hF0};
    @(posedge CLK);
    #1;

    // Reset holds everything idle even with requests present
    cyc(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    cyc(8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0);
    ASYNCRESET = 1'b0;

    // No requests: idle for 5 cycles
    repeat (5) cyc(8'h00, 8'h00, 1'b1, 8'h00, 1'b0);

    // req=81 from ptr=0: grant 0, bubble, grant 7
    cyc(8'h81, 8'h01, 1'b1, 8'h00, 1'b0);
    cyc(8'h81, 8'h01, 1'b1, 8'h01, 1'b0);
    cyc(8'h81, 8'h80, 1'b1, 8'h00, 1'b0);
    cyc(8'h81, 8'h80, 1'b1, 8'h80, 1'b0);
    cyc(8'h00, 8'h00, 1'b1, 8'h00, 1'b0);

    // All requesting, single-beat bursts: rotation 0..7,0 with a bubble between grants
    cyc(8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 9; k++) begin
      cyc(8'hFF, 8'hFF, 1'b1, 8'(1 << (k % 8)), 1'b0);
      cyc((k == 8) ? 8'h00 : 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0);
    end

    // ptr=1: owner 3 four beats with ready toggling, req[5] waiting, stray last bits ignored
    cyc(8'h28, 8'h00, 1'b1, 8'h00, 1'b0);
    cyc(8'h28, 8'h20, 1'b1, 8'h08, 1'b0);
    cyc(8'h28, 8'h28, 1'b0, 8'h08, 1'b0);
    cyc(8'h28, 8'h20, 1'b1, 8'h08, 1'b0);
    cyc(8'h28, 8'h28, 1'b0, 8'h08, 1'b0);
    cyc(8'h28, 8'h20, 1'b1, 8'h08, 1'b0);
    cyc(8'h28, 8'h28, 1'b0, 8'h08, 1'b0);
    cyc(8'h28, 8'h28, 1'b1, 8'h08, 1'b0);
    cyc(8'h28, 8'h00, 1'b1, 8'h00, 1'b0);
    cyc(8'h20, 8'h20, 1'b1, 8'h20, 1'b0);
    cyc(8'h00, 8'h00, 1'b1, 8'h00, 1'b0);

    // ptr=6: owner 2 stalls 15 cycles -> abort, next search from 3 (picks 3 over 0)
    cyc(8'h04, 8'h00, 1'b1, 8'h00, 1'b0);
    cyc(8'h04, 8'h00, 1'b1, 8'h04, 1'b0);
    repeat (15) cyc(8'h09, 8'h09, 1'b1, 8'h04, 1'b0);
    cyc(8'h09, 8'h00, 1'b1, 8'h00, 1'b1);
    cyc(8'h08, 8'h08, 1'b1, 8'h08, 1'b0);
    cyc(8'h00, 8'h00, 1'b1, 8'h00, 1'b0);

    // ptr=4: owner 2 stalls 14 cycles then returns -> no abort
    cyc(8'h04, 8'h00, 1'b1, 8'h00, 1'b0);
    repeat (14) cyc(8'h00, 8'h00, 1'b1, 8'h04, 1'b0);
    cyc(8'h04, 8'h00, 1'b0, 8'h04, 1'b0);
    repeat (3) cyc(8'h00, 8'h00, 1'b1, 8'h04, 1'b0);
    cyc(8'h04, 8'h04, 1'b1, 8'h04, 1'b0);
    cyc(8'h00, 8'h00, 1'b1, 8'h00, 1'b0);

    // ptr=3: owner 4 mid-burst, then asynchronous reset between edges
    cyc(8'h10, 8'h00, 1'b1, 8'h00, 1'b0);
    cyc(8'h10, 8'h00, 1'b1, 8'h10, 1'b0);
    #2;
    ASYNCRESET = 1'b1;
    #1;
    check("rst_gnt",   32'(gnt),   32'h0);
    check("rst_O",     32'(O),     32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    @(posedge CLK);
    #1;
    cyc(8'h10, 8'h00, 1'b1, 8'h00, 1'b0);
    ASYNCRESET = 1'b0;
    cyc(8'h10, 8'h00, 1'b1, 8'h00, 1'b0);
    cyc(8'h10, 8'h10, 1'b1, 8'h10, 1'b0);
    cyc(8'h00, 8'h00, 1'b1, 8'h00, 1'b0);

    @(negedge CLK);
    #1;
    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/round_robin_or_bus_arbiter.md
ROUND_ROBIN_OR_BUS_ARBITER -- requirements
Module: round_robin_or_bus_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 8, number of requesters (fixed at 8 in this revision).
REQ-002 SHALL have parameter WIDTH, default 8, data width per requester.
REQ-003 SHALL have parameter TIMEOUT, default 15, idle cycles before a stalled owner is evicted.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port ASYNCRESET  input  1  asynchronous active-high reset.
REQ-006 SHALL have port req  input  8  per-requester request/valid.
REQ-007 SHALL have port last  input  8  per-requester final-beat marker, sampled only with a handshake.
REQ-008 SHALL have ports I0..I7  input  8 each  per-requester data.
REQ-009 SHALL have port ready  input  1  sink accepts the current beat.
REQ-010 SHALL have port gnt  output  8  registered one-hot grant, or all-zero.
REQ-011 SHALL have port owner  output  3  index of the granted requester, 0 when idle.
REQ-012 SHALL have port valid  output  1  req[owner] AND any gnt bit set.
REQ-013 SHALL have port O  output  8  bitwise OR over i of (I<i> AND {8{gnt[i]}}); 0 when idle.
REQ-014 SHALL have port abort  output  1  one-cycle pulse on timeout eviction.

Function
REQ-015 SHALL implement states IDLE and BUSY.
REQ-016 In IDLE with req nonzero, SHALL select the first set req bit searching ptr, ptr+1, ... mod 8, register it into gnt/owner and enter BUSY next cycle (grant latency 1 cycle).
REQ-017 In IDLE with req zero, SHALL stay in IDLE with gnt=0.
REQ-018 Handshake SHALL occur in BUSY when valid AND ready; one beat transferred per handshake.
REQ-019 Handshake with last[owner]=1 SHALL set ptr=(owner+1) mod 8, clear gnt, and return to IDLE (one bubble cycle before next grant).
REQ-020 Handshake with last[owner]=0 SHALL keep the grant locked; other requests SHALL be ignored until release.
REQ-021 In BUSY, the idle counter SHALL increment on each cycle with req[owner]=0, clear on any cycle with req[owner]=1, and saturate at TIMEOUT.
REQ-022 When the counter reaches TIMEOUT, SHALL pulse abort, set ptr=(owner+1) mod 8, clear gnt and return to IDLE.
REQ-023 ready low SHALL stall without counting toward timeout while req[owner]=1.
REQ-024 last bits of non-owners and last[owner] without handshake SHALL be ignored.
REQ-025 O, valid SHALL be combinational from registered gnt and current inputs; no data storage.
REQ-026 ptr SHALL wrap 7 -> 0.

Reset
REQ-027 ASYNCRESET high SHALL immediately force state=IDLE, gnt=0, owner=0, ptr=0, counter=0, abort=0, hence valid=0, O=0.
REQ-028 Reset mid-burst SHALL discard the burst; after release the first grant SHALL follow REQ-016 from ptr=0.

Structure
REQ-029 Shared package SHALL hold N_REQ, WIDTH, TIMEOUT, the state enum and the counter width (4 bits).
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_pick8 (inputs req, ptr; outputs one-hot, index, any).
REQ-031 The data path SHALL be an AND-mask per requester followed by an 8-input OR reduction per bit.

Verification
REQ-032 Reset, req=8'h00 for 5 cycles -> gnt=0, valid=0, O=0, abort never asserted.
REQ-033 req=8'h81, ptr=0, I0=8'hA5, last[0]=1, ready=1 -> cycle 1 gnt=8'h01, O=8'hA5; cycle 2 gnt=0; cycle 3 gnt=8'h80.
REQ-034 req=8'hFF held, every beat last=1, ready=1 -> grants rotate 0,1,...,7,0 with one idle cycle between each.
REQ-035 Owner 3 sends 4 beats (last on 4th) with ready toggling 1,0,1,0,... while req[5]=1 -> gnt stays 8'h08 until 4th handshake, then 8'h20 after one bubble.
REQ-036 Owner 2 drops req for 15 cycles mid-burst -> abort pulses once on cycle 15, gnt=0 next cycle, next grant searches from 3; dropping for 14 cycles then reasserting -> no abort.
REQ-037 ASYNCRESET asserted mid-burst between clock edges -> gnt=0, O=0 immediately; after release req=8'h10 -> gnt=8'h10 one cycle later.
